// File: rtl/twos_to_signmag_serial_if.sv
// Valid/ready channel pair for the serial two's-complement to sign-magnitude converter.
// The converter takes the slave view; whoever feeds it and drains it takes the master view.
interface twos_to_signmag_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic             out_valid;
    logic             out_ready;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic             min_neg;

    modport slave (
        input  in_valid,
        input  d_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sign,
        output mag,
        output min_neg
    );

    modport master (
        output in_valid,
        output d_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sign,
        input  mag,
        input  min_neg
    );
endinterface

// File: rtl/twos_to_signmag_serial.sv
// Multi-cycle two's-complement to sign-magnitude converter. Negative words are negated
// LSB-first with the copy-until-first-one-then-invert rule; non-negative words bypass.
module twos_to_signmag_serial #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    twos_to_signmag_serial_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG_WORD = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             seen_one_q,  seen_one_d;
    logic             out_valid_q, out_valid_d;
    logic             sign_q,      sign_d;
    logic [WIDTH-1:0] mag_q,       mag_d;
    logic             min_neg_q,   min_neg_d;

    logic             in_ready;
    logic             accept;
    logic             serial_bit;
    logic [WIDTH-1:0] shift_next;

    // Held low during reset so no word can be taken on a reset edge.
    assign in_ready   = (state_q == IDLE) && !reset;
    assign accept     = bus.in_valid && in_ready;

    // Bits up to and including the first one pass through; every later bit inverts.
    assign serial_bit = seen_one_q ? ~shift_q[0] : shift_q[0];
    assign shift_next = {serial_bit, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        seen_one_d  = seen_one_q;
        out_valid_d = out_valid_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        min_neg_d   = min_neg_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d    = bus.d_in[WIDTH-1];
                    min_neg_d = (bus.d_in == MIN_NEG_WORD);
                    if (bus.d_in[WIDTH-1]) begin
                        shift_d    = bus.d_in;
                        cnt_d      = CW'(WIDTH - 1);
                        seen_one_d = 1'b0;
                        state_d    = SHIFT;
                    end else begin
                        mag_d       = bus.d_in;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end

            SHIFT: begin
                shift_d    = shift_next;
                seen_one_d = seen_one_q | shift_q[0];
                cnt_d      = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    mag_d       = shift_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            seen_one_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            min_neg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            seen_one_q  <= seen_one_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            min_neg_q   <= min_neg_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sign      = sign_q;
    assign bus.mag       = mag_q;
    assign bus.min_neg   = min_neg_q;
endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Self-checking bench: directed corner cases, backpressure, mid-shift reset, and a
// randomized run scored against an arithmetic |x| reference.
module tb_twos_to_signmag_serial;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    twos_to_signmag_serial_if #(.WIDTH(WIDTH)) bus ();

    twos_to_signmag_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain signed arithmetic.
    function automatic logic [33:0] ref_result(input logic [31:0] d);
        longint v;
        longint a;
        logic [63:0] a_bits;
        logic        s;
        v      = longint'($signed(d));
        s      = (v < 0);
        a      = s ? -v : v;
        a_bits = 64'(a);
        return {s, (v == -longint'(64'h8000_0000)), a_bits[31:0]};
    endfunction

    // Accept one word with out_ready held high and check latency, busy and result.
    task automatic run_word(input string tag, input logic [31:0] d, input int exp_lat);
        int          lat;
        logic        busy_ok;
        logic [33:0] e;
        e = ref_result(d);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.d_in      = d;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            step();
            lat++;
        end
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, {30'd0, bus.sign, bus.min_neg, bus.mag}, {30'd0, e});
        $display("word %s d_in=%08h sign=%0b mag=%08h min_neg=%0b latency=%0d",
                 tag, d, bus.sign, bus.mag, bus.min_neg, lat);
        step();
        chk({tag, "_drain"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    endtask

    initial begin
        int          lat;
        logic [33:0] e;
        logic [31:0] d;
        logic [33:0] expq[$];
        logic [31:0] dq[$];
        int          accepted;
        int          handshakes;
        int          cycles;

        bus.in_valid  = 1'b0;
        bus.d_in      = '0;
        bus.out_ready = 1'b0;

        // Reset behaviour
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_state", {29'd0, bus.out_valid, bus.sign, bus.min_neg, bus.in_ready, bus.mag},
            {29'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});

        // Directed words
        run_word("pos5",    32'h0000_0005, 1);
        run_word("neg5",    32'hFFFF_FFFB, 33);
        run_word("minneg",  32'h8000_0000, 33);
        run_word("allones", 32'hFFFF_FFFF, 33);
        run_word("zero",    32'h0000_0000, 1);
        run_word("maxpos",  32'h7FFF_FFFF, 1);

        // Backpressure with a competing input word
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.d_in      = 32'hFFFF_FF00;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd33);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.d_in     = 32'h0000_0007;
            chk("bp_hold", {29'd0, bus.out_valid, bus.in_ready, bus.sign, bus.mag},
                {29'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0100});
            step();
        end
        $display("word bp d_in=ffffff00 sign=%0b mag=%08h held 10 cycles", bus.sign, bus.mag);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        step();
        bus.in_valid = 1'b0;
        chk("bp_next_result", {29'd0, bus.out_valid, bus.sign, bus.min_neg, bus.mag},
            {29'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0007});
        $display("word bp_next d_in=00000007 sign=%0b mag=%08h", bus.sign, bus.mag);
        step();

        // Reset on the 10th shift cycle drops the word
        bus.in_valid = 1'b1;
        bus.d_in     = 32'hFFFF_FFF0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i < 10; i++) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) lat++;
            step();
        end
        chk("dropped_no_valid", 64'(lat), 64'd0);
        $display("word dropped d_in=fffffff0 by reset");
        run_word("after_rst", 32'hFFFF_FFF0, 33);

        // Randomized run with random gaps on both handshakes
        accepted   = 0;
        handshakes = 0;
        cycles     = 0;
        while ((accepted < 1000 || expq.size() != 0) && cycles < 90000) begin
            bus.in_valid  = (accepted < 1000) && ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       d = 32'h8000_0000;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'h0000_0000;
                default: d = $urandom;
            endcase
            bus.d_in      = d;
            bus.out_ready = ($urandom_range(0, 9) < 6);
            if (bus.out_valid && bus.out_ready) begin
                handshakes++;
                if (expq.size() == 0) begin
                    chk("rnd_spurious", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    d = dq.pop_front();
                    chk("rnd_result", {30'd0, bus.sign, bus.min_neg, bus.mag}, {30'd0, e});
                    $display("rnd %0d d_in=%08h sign=%0b mag=%08h min_neg=%0b",
                             handshakes, d, bus.sign, bus.mag, bus.min_neg);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                accepted++;
                expq.push_back(ref_result(bus.d_in));
                dq.push_back(bus.d_in);
            end
            step();
            cycles++;
        end
        chk("rnd_timeout", 64'(cycles < 90000), 64'd1);
        chk("rnd_handshakes", 64'(handshakes), 64'(accepted));
        chk("rnd_accepted", 64'(accepted), 64'd1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
